// File: rtl/id_stage_pipelined.sv
// ============================================================================
// id_stage_pipelined
// ----------------------------------------------------------------------------
// Instruction-decode stage for the MIPS kernel with a registered ID/EX
// boundary. Decodes one instruction per cycle into an execute command,
// operands and control enables. Includes a valid/ready handshake, a load-use
// stall and a branch flush.
//
// Optional feature (compile-time macro):
//   ID_WB_BYPASS_EN : forwards the writeback port (i_wb_*) into the operand
//                     read path, so the register file does not need to be
//                     write-first. With the macro undefined, operands come
//                     only from i_reg_1 / i_reg_2.
//
// Ports:
//   i_sys_clk, i_sys_rst       clock, asynchronous active-high reset
//   i_instr, i_instr_valid     instruction from fetch and its valid flag
//   o_instr_ready              the stage accepts i_instr this cycle
//   o_src_addr1/2              combinational register-file read addresses
//   i_reg_1/2                  register-file read data (same cycle)
//   i_flush                    branch-taken flush from execute
//   i_ex_ready                 execute accepts the ID/EX contents
//   i_wb_en/addr/data          writeback port (used only by the bypass)
//   o_valid                    ID/EX holds a valid instruction
//   o_exe_cmd                  ALU command
//   o_value1/2                 operands (o_value2 = immediate for I-type ALU)
//   o_store_data               rt value for SW
//   o_dest_addr                destination register
//   o_writeback_en, o_mem_rd_en, o_mem_wr_en, o_branch   registered control
// ============================================================================
module id_stage_pipelined #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int IMM_SIGNED   = 1,
    parameter int EXE_CMD_LEN  = 4
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic [31:0]             i_instr,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic [WORD_LEN-1:0]     i_reg_1,
    input  logic [WORD_LEN-1:0]     i_reg_2,
    output logic [REG_ADDR_LEN-1:0] o_src_addr1,
    output logic [REG_ADDR_LEN-1:0] o_src_addr2,
    input  logic                    i_flush,
    input  logic                    i_ex_ready,
    input  logic                    i_wb_en,
    input  logic [REG_ADDR_LEN-1:0] i_wb_addr,
    input  logic [WORD_LEN-1:0]     i_wb_data,
    output logic                    o_valid,
    output logic [EXE_CMD_LEN-1:0]  o_exe_cmd,
    output logic [WORD_LEN-1:0]     o_value1,
    output logic [WORD_LEN-1:0]     o_value2,
    output logic [WORD_LEN-1:0]     o_store_data,
    output logic [REG_ADDR_LEN-1:0] o_dest_addr,
    output logic                    o_writeback_en,
    output logic                    o_mem_rd_en,
    output logic                    o_mem_wr_en,
    output logic                    o_branch
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    localparam logic [EXE_CMD_LEN-1:0] CMD_NOP = '0;
    localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(1);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(2);
    localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(3);
    localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = EXE_CMD_LEN'(4);

    // Decoded control for the instruction currently at the input.
    typedef struct packed {
        logic [EXE_CMD_LEN-1:0] cmd;
        logic                   is_imm;
        logic                   reads_rt;
        logic                   wb_en;
        logic                   mem_rd;
        logic                   mem_wr;
        logic                   branch;
    } dec_t;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]              opcode;
    logic [5:0]              funct;
    logic                    is_rtype;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [WORD_LEN-1:0]     imm_ext;

    assign opcode   = i_instr[31:26];
    assign funct    = i_instr[5:0];
    assign is_rtype = (opcode == OP_RTYPE);
    assign src1     = REG_ADDR_LEN'(i_instr[25:21]);
    assign src2     = REG_ADDR_LEN'(i_instr[20:16]);
    assign dest     = is_rtype ? REG_ADDR_LEN'(i_instr[15:11])
                               : REG_ADDR_LEN'(i_instr[20:16]);

    assign o_src_addr1 = src1;
    assign o_src_addr2 = src2;

    assign imm_ext = {{(WORD_LEN-16){(IMM_SIGNED != 0) & i_instr[15]}},
                      i_instr[15:0]};

    // ------------------------------------------------------------------
    // Decode. Unrecognised encodings fall through as a NOP (cmd 0, no
    // enables) but still occupy a valid slot downstream.
    // ------------------------------------------------------------------
    dec_t dec;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                // Every R-type reads rt, even an unknown funct, so it is
                // treated as an rt consumer for hazard purposes.
                dec.reads_rt = 1'b1;
                case (funct)
                    FN_ADD: begin dec.cmd = CMD_ADD; dec.wb_en = 1'b1; end
                    FN_SUB: begin dec.cmd = CMD_SUB; dec.wb_en = 1'b1; end
                    FN_AND: begin dec.cmd = CMD_AND; dec.wb_en = 1'b1; end
                    FN_OR:  begin dec.cmd = CMD_OR;  dec.wb_en = 1'b1; end
                    default: dec.cmd = CMD_NOP;
                endcase
            end
            OP_ADDI: begin
                dec.cmd    = CMD_ADD;
                dec.is_imm = 1'b1;
                dec.wb_en  = 1'b1;
            end
            OP_LW: begin
                dec.cmd    = CMD_ADD;
                dec.is_imm = 1'b1;
                dec.mem_rd = 1'b1;
                dec.wb_en  = 1'b1;
            end
            OP_SW: begin
                dec.cmd      = CMD_ADD;
                dec.is_imm   = 1'b1;
                dec.mem_wr   = 1'b1;
                dec.reads_rt = 1'b1;
            end
            OP_BEQ: begin
                dec.cmd      = CMD_SUB;
                dec.branch   = 1'b1;
                dec.reads_rt = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand read. r0 is hard-wired to zero ahead of any bypass.
    // ------------------------------------------------------------------
    logic [WORD_LEN-1:0] rs_val;
    logic [WORD_LEN-1:0] rt_val;

`ifdef ID_WB_BYPASS_EN
    always_comb begin
        if (src1 == '0)                          rs_val = '0;
        else if (i_wb_en && (i_wb_addr == src1)) rs_val = i_wb_data;
        else                                     rs_val = i_reg_1;

        if (src2 == '0)                          rt_val = '0;
        else if (i_wb_en && (i_wb_addr == src2)) rt_val = i_wb_data;
        else                                     rt_val = i_reg_2;
    end
`else
    assign rs_val = (src1 == '0) ? '0 : i_reg_1;
    assign rt_val = (src2 == '0) ? '0 : i_reg_2;

    // Writeback port only feeds the bypass; fold it away here.
    logic unused_wb;
    assign unused_wb = ^{i_wb_en, i_wb_addr, i_wb_data};
`endif

    // ------------------------------------------------------------------
    // Load-use hazard: the slot in ID/EX is a load whose destination
    // the incoming instruction reads. Stalling until EX takes the load
    // lets the slot drain, which clears the hazard on the following
    // cycle, so each load-use pair costs exactly one bubble.
    // ------------------------------------------------------------------
    logic hazard;
    logic accept;

    assign hazard = o_valid && o_mem_rd_en && (o_dest_addr != '0) &&
                    ((o_dest_addr == src1) ||
                     ((o_dest_addr == src2) && dec.reads_rt));

    assign o_instr_ready = (!o_valid || i_ex_ready) && !hazard;
    assign accept        = i_instr_valid && o_instr_ready;

    // ------------------------------------------------------------------
    // ID/EX register. Priority: flush > load > hold > drain.
    // On flush/drain only the valid bit and enables are cleared; the
    // data fields are don't-care while o_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            o_valid        <= 1'b0;
            o_exe_cmd      <= '0;
            o_value1       <= '0;
            o_value2       <= '0;
            o_store_data   <= '0;
            o_dest_addr    <= '0;
            o_writeback_en <= 1'b0;
            o_mem_rd_en    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_branch       <= 1'b0;
        end else if (i_flush) begin
            // The fetch may still be consumed (ready unchanged) but is
            // discarded here.
            o_valid        <= 1'b0;
            o_writeback_en <= 1'b0;
            o_mem_rd_en    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_branch       <= 1'b0;
        end else if (accept) begin
            o_valid        <= 1'b1;
            o_exe_cmd      <= dec.cmd;
            o_value1       <= rs_val;
            o_value2       <= dec.is_imm ? imm_ext : rt_val;
            o_store_data   <= rt_val;
            o_dest_addr    <= dest;
            o_writeback_en <= dec.wb_en;
            o_mem_rd_en    <= dec.mem_rd;
            o_mem_wr_en    <= dec.mem_wr;
            o_branch       <= dec.branch;
        end else if (!o_valid || i_ex_ready) begin
            // Slot consumed (or already empty) with nothing new: bubble.
            o_valid        <= 1'b0;
            o_writeback_en <= 1'b0;
            o_mem_rd_en    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_branch       <= 1'b0;
        end
        // else: o_valid && !i_ex_ready -> hold everything.
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// ============================================================================
// tb_id_stage_pipelined
// ----------------------------------------------------------------------------
// Scoreboard bench. The driver issues one cycle of stimulus at a time,
// predicts from an abstract model whether the stage should accept it, and
// queues the expected ID/EX contents. A negedge monitor compares the DUT
// against the head of the queue and retires entries as EX consumes them
// (or a flush kills them). A second instance with IMM_SIGNED=0 shares the
// inputs so zero-extension is covered in the same run.
// ============================================================================
module tb_id_stage_pipelined;

    localparam int W = 32;
    localparam int A = 5;
    localparam int C = 4;

    logic         clk;
    logic         rst;
    logic [31:0]  i_instr;
    logic         i_instr_valid;
    logic [W-1:0] i_reg_1, i_reg_2;
    logic         i_flush, i_ex_ready;
    logic         i_wb_en;
    logic [A-1:0] i_wb_addr;
    logic [W-1:0] i_wb_data;

    logic         o_instr_ready, o_valid;
    logic [A-1:0] o_src_addr1, o_src_addr2, o_dest_addr;
    logic [C-1:0] o_exe_cmd;
    logic [W-1:0] o_value1, o_value2, o_store_data;
    logic         o_writeback_en, o_mem_rd_en, o_mem_wr_en, o_branch;

    logic         z_instr_ready, z_valid;
    logic [A-1:0] z_src_addr1, z_src_addr2, z_dest_addr;
    logic [C-1:0] z_exe_cmd;
    logic [W-1:0] z_value1, z_value2, z_store_data;
    logic         z_writeback_en, z_mem_rd_en, z_mem_wr_en, z_branch;

    id_stage_pipelined #(.WORD_LEN(W), .REG_ADDR_LEN(A), .IMM_SIGNED(1), .EXE_CMD_LEN(C)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
        .o_instr_ready(o_instr_ready), .i_reg_1(i_reg_1), .i_reg_2(i_reg_2),
        .o_src_addr1(o_src_addr1), .o_src_addr2(o_src_addr2), .i_flush(i_flush),
        .i_ex_ready(i_ex_ready), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .o_exe_cmd(o_exe_cmd), .o_value1(o_value1), .o_value2(o_value2),
        .o_store_data(o_store_data), .o_dest_addr(o_dest_addr), .o_writeback_en(o_writeback_en),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en), .o_branch(o_branch));

    id_stage_pipelined #(.WORD_LEN(W), .REG_ADDR_LEN(A), .IMM_SIGNED(0), .EXE_CMD_LEN(C)) dut_z (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
        .o_instr_ready(z_instr_ready), .i_reg_1(i_reg_1), .i_reg_2(i_reg_2),
        .o_src_addr1(z_src_addr1), .o_src_addr2(z_src_addr2), .i_flush(i_flush),
        .i_ex_ready(i_ex_ready), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(z_valid), .o_exe_cmd(z_exe_cmd), .o_value1(z_value1), .o_value2(z_value2),
        .o_store_data(z_store_data), .o_dest_addr(z_dest_addr), .o_writeback_en(z_writeback_en),
        .o_mem_rd_en(z_mem_rd_en), .o_mem_wr_en(z_mem_wr_en), .o_branch(z_branch));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [C-1:0] cmd;
        logic [W-1:0] v1, v2, v2z, sd;
        logic [A-1:0] dest;
        logic         wb, rd, wr, br;
    } exp_t;

    exp_t q[$];
    exp_t pend_rec, mon_e;
    logic pend;
    logic exp_ready;
    int   checks;
    int   failures;

    function automatic logic [W-1:0] rf_read(input logic [4:0] a, input logic [W-1:0] rf_val,
                                             input logic wen, input logic [A-1:0] wa,
                                             input logic [W-1:0] wd);
        if (a == 5'd0) return '0;
`ifdef ID_WB_BYPASS_EN
        if (wen && wa == a) return wd;
`endif
        return rf_val;
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [W-1:0] r1, input logic [W-1:0] r2,
                                   input logic wen, input logic [A-1:0] wa, input logic [W-1:0] wd);
        exp_t e;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [W-1:0] rsv, rtv;
        op  = ins[31:26];
        imm = ins[15:0];
        rsv = rf_read(ins[25:21], r1, wen, wa, wd);
        rtv = rf_read(ins[20:16], r2, wen, wa, wd);
        e.cmd = '0; e.wb = 0; e.rd = 0; e.wr = 0; e.br = 0;
        e.v1 = rsv; e.v2 = rtv; e.v2z = rtv; e.sd = rtv;
        e.dest = (op == 6'h00) ? ins[15:11] : ins[20:16];
        case (op)
            6'h00: case (ins[5:0])
                6'h20: begin e.cmd = 1; e.wb = 1; end
                6'h22: begin e.cmd = 2; e.wb = 1; end
                6'h24: begin e.cmd = 3; e.wb = 1; end
                6'h25: begin e.cmd = 4; e.wb = 1; end
                default: ;
            endcase
            6'h08, 6'h23, 6'h2B: begin
                e.cmd = 1;
                e.v2  = {{16{imm[15]}}, imm};
                e.v2z = {16'h0000, imm};
                e.wb  = (op != 6'h2B);
                e.rd  = (op == 6'h23);
                e.wr  = (op == 6'h2B);
            end
            6'h04: begin e.cmd = 2; e.br = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one cycle of stimulus, with prediction of acceptance.
    // ------------------------------------------------------------------
    task automatic cycle(input logic [31:0] ins, input logic v, input logic [W-1:0] r1,
                         input logic [W-1:0] r2, input logic exr, input logic fl);
        logic hz;
        @(posedge clk); #1;
        if (pend) q.push_back(pend_rec);
        pend = 0;
        i_instr = ins; i_instr_valid = v; i_reg_1 = r1; i_reg_2 = r2;
        i_ex_ready = exr; i_flush = fl;
        i_wb_en = 1'($urandom_range(0, 1));
        i_wb_addr = A'($urandom_range(0, 3));
        i_wb_data = $urandom;
        // Stall when the slot holds a load whose target the new instruction reads.
        hz = (q.size() > 0) && q[0].rd && (q[0].dest != 0) &&
             ((q[0].dest == ins[25:21]) || ((q[0].dest == ins[20:16]) && reads_rt(ins[31:26])));
        exp_ready = ((q.size() == 0) || exr) && !hz;
        pend = v && exp_ready && !fl;
        pend_rec = model(ins, r1, r2, i_wb_en, i_wb_addr, i_wb_data);
    endtask

    // Present an instruction with EX ready until it is taken (bounded).
    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        do begin
            cycle(ins, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
            n++;
        end while (!pend && n < 10);
        checks++;
        if (!pend) begin
            failures++;
            $display("FAIL send_timeout got=not_accepted exp=accepted instr=%h", ins);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_enables", {28'b0, o_writeback_en, o_mem_rd_en, o_mem_wr_en, o_branch}, 0);
        chk("rst_cmd", 32'(o_exe_cmd), 0);
        chk("rst_value1", o_value1, 0);
        chk("rst_value2", o_value2, 0);
        chk("rst_store", o_store_data, 0);
        chk("rst_dest", 32'(o_dest_addr), 0);
        chk("rst_valid_z", 32'(z_valid), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        i_instr_valid = 0; i_flush = 0;
        q.delete(); pend = 0; exp_ready = 1;
        #2;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        int sel;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        sel = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; default: fn = 6'h25;
        endcase
        case (sel)
            0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'd0, fn};
            4: return {6'h08, rs, rt, 16'($urandom)};
            5, 6: return {6'h23, rs, rt, 16'($urandom)};
            7: return {6'h2B, rs, rt, 16'($urandom)};
            8: return {6'h04, rs, rt, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("instr_ready", 32'(o_instr_ready), 32'(exp_ready));
            if (o_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(o_valid), 0);
                end else begin
                    mon_e = q[0];
                    chk("exe_cmd", 32'(o_exe_cmd), 32'(mon_e.cmd));
                    chk("value1", o_value1, mon_e.v1);
                    chk("value2", o_value2, mon_e.v2);
                    chk("value2_zext", z_value2, mon_e.v2z);
                    chk("store_data", o_store_data, mon_e.sd);
                    chk("dest_addr", 32'(o_dest_addr), 32'(mon_e.dest));
                    chk("enables", {28'b0, o_writeback_en, o_mem_rd_en, o_mem_wr_en, o_branch},
                        {28'b0, mon_e.wb, mon_e.rd, mon_e.wr, mon_e.br});
                    chk("valid_z", 32'(z_valid), 1);
                    if (i_ex_ready || i_flush) void'(q.pop_front());
                end
            end else begin
                chk("valid", 32'(o_valid), 32'(q.size() != 0));
                chk("idle_enables", {28'b0, o_writeback_en, o_mem_rd_en, o_mem_wr_en, o_branch}, 0);
                q.delete();
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        checks = 0; failures = 0; pend = 0; exp_ready = 1;
        rst = 0; i_instr = 0; i_instr_valid = 0; i_reg_1 = 0; i_reg_2 = 0;
        i_flush = 0; i_ex_ready = 0; i_wb_en = 0; i_wb_addr = 0; i_wb_data = 0;
        #1 rst = 1;
        #2 check_reset_state();
        @(posedge clk); #1 rst = 0;

        // ADD r3,r1,r2 with r1=5, r2=7
        cycle({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 1, 32'd5, 32'd7, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        // ADDI r4,r1,0xFFFF: sign- and zero-extended via the two instances
        send({6'h08, 5'd1, 5'd4, 16'hFFFF});
        cycle(0, 0, 0, 0, 1, 0);
        // LW r2,0(r1) then dependent ADD r5,r2,r6: one bubble
        send({6'h23, 5'd1, 5'd2, 16'h0000});
        send({6'h00, 5'd2, 5'd6, 5'd5, 5'd0, 6'h20});
        cycle(0, 0, 0, 0, 1, 0);
        // SW held by EX backpressure for 3 cycles, then released
        send({6'h2B, 5'd1, 5'd3, 16'h0010});
        repeat (3) cycle({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h22}, 1, $urandom, $urandom, 0, 0);
        send({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h22});
        cycle(0, 0, 0, 0, 1, 0);
        // Flush coincident with a valid BEQ, and flush of a held slot
        cycle({6'h04, 5'd1, 5'd2, 16'h0004}, 1, $urandom, $urandom, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24});
        cycle({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 1, $urandom, $urandom, 0, 1);
        cycle(0, 0, 0, 0, 1, 0);
        // Register 0 source with nonzero read data
        send({6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h25});
        cycle(0, 0, 0, 0, 1, 0);
        // Reset in the middle of a load-use stall
        send({6'h23, 5'd1, 5'd2, 16'h0004});
        cycle({6'h00, 5'd2, 5'd1, 5'd4, 5'd0, 6'h20}, 1, $urandom, $urandom, 0, 0);
        do_reset();
        send({6'h00, 5'd2, 5'd1, 5'd4, 5'd0, 6'h20});

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(rand_instr(), 1'($urandom_range(0, 9) < 8), $urandom, $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
        end
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
